// File: rtl/rs_hs_pipeline_pkg.sv
// Shared definitions for the pipelined FIFO-handshake relay chain:
// storage style encodings, physical depth sizing and pointer wrap helper.
package rs_hs_pipeline_pkg;

  localparam int MEM_STYLE_LUT = 0;
  localparam int MEM_STYLE_REG = 1;

  // Physical entries: producer-visible depth, grace margin, plus a small slack.
  function automatic int real_depth(input int depth, input int grace);
    return grace + depth + 32'sd4;
  endfunction

  // Pointer increment that wraps at an arbitrary (non power-of-two) limit.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned limit);
    int unsigned nxt;
    if (ptr == limit - 32'd1) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rs_hs_pipeline_tail_mem.sv
// Storage array for the relay-chain tail FIFO: one synchronous write port,
// one asynchronous read port; MEM_STYLE picks the ram_style attribute.
module rs_hs_pipeline_tail_mem
  import rs_hs_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REAL_DEPTH = 33,
  parameter int ADDR_WIDTH = 6,
  parameter int MEM_STYLE  = MEM_STYLE_LUT
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  if (MEM_STYLE == MEM_STYLE_REG) begin : g_reg
    (* ram_style = "registers" *) logic [DATA_WIDTH-1:0] mem [REAL_DEPTH];

    // Write port
    always_ff @(posedge clk) begin
      if (we) begin
        mem[waddr] <= wdata;
      end
    end

    assign rdata = mem[raddr];
  end else begin : g_lut
    (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [REAL_DEPTH];

    // Write port
    always_ff @(posedge clk) begin
      if (we) begin
        mem[waddr] <= wdata;
      end
    end

    assign rdata = mem[raddr];
  end

endmodule

// File: rtl/rs_hs_pipeline_tail_fifo.sv
// Tail stage of the relay chain: circular buffer whose if_full_n drops
// GRACE_PERIOD entries early so in-flight words are still absorbed losslessly.
module rs_hs_pipeline_tail_fifo
  import rs_hs_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 24,
  parameter int GRACE_PERIOD = 5,
  parameter int MEM_STYLE    = MEM_STYLE_LUT,
  parameter int REAL_DEPTH   = real_depth(DEPTH, GRACE_PERIOD),
  parameter int ADDR_WIDTH   = $clog2(REAL_DEPTH),
  parameter int COUNT_WIDTH  = $clog2(REAL_DEPTH + 1),
  parameter int FULL_THRESH  = REAL_DEPTH - GRACE_PERIOD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_write,
  input  logic [DATA_WIDTH-1:0]  if_din,
  output logic                   if_full_n,
  input  logic                   if_read,
  output logic [DATA_WIDTH-1:0]  if_dout,
  output logic                   if_empty_n,
  output logic [COUNT_WIDTH-1:0] occupancy,
  output logic                   overflow
);

  if ((GRACE_PERIOD >= REAL_DEPTH) || (DEPTH < 1)) begin : g_param_err
    $error("rs_hs_pipeline_tail_fifo: need GRACE_PERIOD < REAL_DEPTH and DEPTH >= 1");
  end

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO   = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_FULL   = COUNT_WIDTH'(REAL_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_THRESH = COUNT_WIDTH'(FULL_THRESH);

  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   full_n_q, full_n_d;
  logic                   empty_n_q, empty_n_d;
  logic                   overflow_q, overflow_d;
  logic                   rd_en;
  logic                   wr_en;

  // Next-state: if_full_n is intentionally absent from wr_en; only physical space gates writes.
  always_comb begin
    rd_en    = if_read & (count_q != CNT_ZERO);
    wr_en    = if_write & ((count_q != CNT_FULL) | rd_en);
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (wr_en) begin
      wr_ptr_d = ADDR_WIDTH'(next_ptr(32'(wr_ptr_q), unsigned'(REAL_DEPTH)));
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en) begin
      rd_ptr_d = ADDR_WIDTH'(next_ptr(32'(rd_ptr_q), unsigned'(REAL_DEPTH)));
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    full_n_d   = (count_d < CNT_THRESH);
    empty_n_d  = (count_d != CNT_ZERO);
    overflow_d = overflow_q | (if_write & ~wr_en);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q   <= {ADDR_WIDTH{1'b0}};
      count_q    <= CNT_ZERO;
      full_n_q   <= 1'b1;
      empty_n_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_n_q   <= full_n_d;
      empty_n_q  <= empty_n_d;
      overflow_q <= overflow_d;
    end
  end

  rs_hs_pipeline_tail_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .REAL_DEPTH(REAL_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_STYLE (MEM_STYLE)
  ) u_mem (
    .clk  (clk),
    .we   (wr_en & ~reset),
    .waddr(wr_ptr_q),
    .wdata(if_din),
    .raddr(rd_ptr_q),
    .rdata(if_dout)
  );

  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;
  assign occupancy  = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rs_hs_pipeline_tail_fifo.sv
// Directed bench for the relay-chain tail FIFO with a queue scoreboard and
// a small occupancy/flag reference model derived from the behaviour description.
module tb_rs_hs_pipeline_tail_fifo;

  localparam int DW      = 32;
  localparam int RDEPTH  = 33;
  localparam int THRESH  = 28;
  localparam int CW      = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_full_n;
  logic          if_read;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic [CW-1:0] occupancy;
  logic          overflow;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb[$];
  int            m_cnt = 0;
  logic          m_ovf = 1'b0;

  rs_hs_pipeline_tail_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .if_write  (if_write),
    .if_din    (if_din),
    .if_full_n (if_full_n),
    .if_read   (if_read),
    .if_dout   (if_dout),
    .if_empty_n(if_empty_n),
    .occupancy (occupancy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    chk({tag, ":occupancy"}, 32'(occupancy), 32'(m_cnt));
    chk({tag, ":empty_n"}, 32'(if_empty_n), 32'(m_cnt != 0));
    chk({tag, ":full_n"}, 32'(if_full_n), 32'(m_cnt < THRESH));
    chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: drive, predict, check head word on a valid read, clock, check flags.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input string tag);
    logic rd, wr;
    if_write = w;
    if_din   = d;
    if_read  = r;
    rd = r && (m_cnt != 0);
    wr = w && ((m_cnt != RDEPTH) || rd);
    if (rd) begin
      if (sb.size() == 0) begin
        chk({tag, ":sb_underflow"}, 32'd1, 32'd0);
      end else begin
        chk({tag, ":dout"}, if_dout, sb.pop_front());
      end
    end
    if (wr) sb.push_back(d);
    if (w && !wr) m_ovf = 1'b1;
    m_cnt = m_cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
    @(posedge clk);
    #1;
    check_flags(tag);
  endtask

  task automatic do_reset(input logic w);
    reset    = 1'b1;
    if_write = w;
    if_din   = 32'h0000_0BAD;
    if_read  = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    if_write = 1'b0;
    sb.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    chk("reset:occupancy", 32'(occupancy), 32'd0);
    chk("reset:empty_n", 32'(if_empty_n), 32'd0);
    chk("reset:full_n", 32'(if_full_n), 32'd1);
    chk("reset:overflow", 32'(overflow), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    if_write = 1'b0;
    if_din   = 32'h0;
    if_read  = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // Fill from reset: full_n must fall right after the 28th accepted write.
    for (int i = 1; i <= RDEPTH; i++) begin
      cycle(1'b1, 32'(i), 1'b0, "fill");
      if (i == THRESH - 1) chk("fill:full_n_before_thresh", 32'(if_full_n), 32'd1);
      if (i == THRESH) chk("fill:full_n_at_thresh", 32'(if_full_n), 32'd0);
    end
    chk("fill:occ33", 32'(occupancy), 32'd33);
    chk("fill:no_ovf", 32'(overflow), 32'd0);

    // Dropped write at physical full.
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, "ovf");
    chk("ovf:set", 32'(overflow), 32'd1);
    chk("ovf:occ33", 32'(occupancy), 32'd33);

    // Read+write at full: count holds, new word goes to the tail.
    cycle(1'b1, 32'd34, 1'b1, "full_rw");
    chk("full_rw:occ33", 32'(occupancy), 32'd33);

    // Drain everything; order and absence of the dropped word checked by the scoreboard.
    for (int i = 0; i < RDEPTH; i++) begin
      if (if_dout === 32'hDEAD_BEEF) chk("drain:dropped_word_seen", if_dout, 32'd0);
      cycle(1'b0, 32'h0, 1'b1, "drain");
    end
    chk("drain:ovf_sticky", 32'(overflow), 32'd1);

    // Reads while empty are ignored.
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1, "empty_rd");
    cycle(1'b1, 32'h1234, 1'b0, "empty_wr");
    chk("empty_wr:dout", if_dout, 32'h1234);
    cycle(1'b0, 32'h0, 1'b1, "empty_drain");

    // Read+write at count 0: write accepted, no fall-through.
    cycle(1'b1, 32'h55, 1'b1, "zero_rw");
    chk("zero_rw:occ1", 32'(occupancy), 32'd1);
    chk("zero_rw:empty_n", 32'(if_empty_n), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, "zero_drain");

    // Streaming wrap: 100 words through a shallow occupancy, pointers wrap several times.
    do_reset(1'b0);
    cycle(1'b1, 32'd0, 1'b0, "wrap_prime");
    cycle(1'b1, 32'd1, 1'b0, "wrap_prime");
    for (int i = 2; i < 100; i++) cycle(1'b1, 32'(i), 1'b1, "wrap");
    cycle(1'b0, 32'h0, 1'b1, "wrap_drain");
    cycle(1'b0, 32'h0, 1'b1, "wrap_drain");
    chk("wrap:sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-operation with a simultaneous write.
    for (int i = 0; i < 17; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, "pre_rst");
    chk("pre_rst:occ17", 32'(occupancy), 32'd17);
    do_reset(1'b1);
    cycle(1'b1, 32'hA1, 1'b0, "post_rst");
    cycle(1'b1, 32'hA2, 1'b0, "post_rst");
    chk("post_rst:first_word", if_dout, 32'hA1);
    cycle(1'b0, 32'h0, 1'b1, "post_rst_drain");
    cycle(1'b0, 32'h0, 1'b1, "post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_hs_pipeline_tail_fifo.md
Name: rs_hs_pipeline_tail_fifo

Overview:
Receiving end of the pipelined FIFO-handshake relay chain. It is the tail stage that absorbs in-flight words still travelling through head and body relay registers after it deasserts if_full_n. It is a circular buffer with a grace-period margin: if_full_n drops early, and up to GRACE_PERIOD further writes are still accepted losslessly. It drives the consumer-facing show-ahead read interface (if_dout / if_empty_n / if_read).

Parameters:
DATA_WIDTH, 32, word width.
DEPTH, 24, usable depth seen by the producer before backpressure.
GRACE_PERIOD, 5, max writes that can arrive after if_full_n deasserts (pipeline round-trip latency).
MEM_STYLE, 0, storage style: 0 = distributed/LUT RAM, 1 = registers. Attribute only; no behavioural difference.
REAL_DEPTH, GRACE_PERIOD + DEPTH + 4, physical entries (default 33).
ADDR_WIDTH, $clog2(REAL_DEPTH), pointer width (default 6).
COUNT_WIDTH, $clog2(REAL_DEPTH + 1), occupancy width (default 6).
FULL_THRESH, REAL_DEPTH - GRACE_PERIOD, occupancy at which if_full_n drops (default 28).

Ports:
clk  in  1  single clock.
reset  in  1  synchronous, active-high reset.
if_write  in  1  write strobe from the last body stage; not qualified by if_full_n.
if_din  in  DATA_WIDTH  write data.
if_full_n  out  1  registered "not almost full".
if_read  in  1  consumer read strobe.
if_dout  out  DATA_WIDTH  head-of-queue word; valid when if_empty_n = 1.
if_empty_n  out  1  registered "not empty".
occupancy  out  COUNT_WIDTH  current stored word count.
overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset (clk edge with reset = 1) sets: wr_ptr = 0, rd_ptr = 0, count = 0, if_full_n = 1, if_empty_n = 0, overflow = 0. Memory contents are not reset. Reset wins over any simultaneous read or write.
- rd_en = if_read & (count != 0). A read while empty is ignored.
- wr_en = if_write & ((count != REAL_DEPTH) | rd_en). if_full_n is deliberately not in this term: writes are accepted while if_full_n = 0 as long as physical space exists.
- Write at full with a simultaneous valid read is accepted; count stays REAL_DEPTH.
- Write and read at count = 0: the write is accepted and the read is ignored (no same-cycle fall-through). count becomes 1.
- Dropped write (if_write = 1, count = REAL_DEPTH, no rd_en): data is discarded and overflow is set to 1 until reset.
- count_next = count + wr_en - rd_en. count and occupancy register count_next.
- if_full_n <= (count_next < FULL_THRESH). if_empty_n <= (count_next != 0). Both update one cycle after the causing event.
- Write-to-read latency is 1 cycle: a word written at edge N gives if_empty_n = 1 and valid if_dout after edge N.
- if_dout = mem[rd_ptr], a combinational read of storage. It is stable while if_empty_n = 1 and no read occurs. Its value when empty is don't-care.
- Pointers increment on wr_en / rd_en and wrap from REAL_DEPTH-1 to 0. REAL_DEPTH is not required to be a power of two, so the wrap uses an explicit compare, not bit truncation.
- Ordering is strict FIFO; no word is ever duplicated or reordered.
- Elaboration check: GRACE_PERIOD < REAL_DEPTH and DEPTH >= 1. Otherwise $error.

Decomposition:
- Shared package rs_hs_pipeline_pkg holds:
  - MEM_STYLE encodings (MEM_STYLE_LUT = 0, MEM_STYLE_REG = 1);
  - a function real_depth(depth, grace) returning grace + depth + 4, shared with the chain wrapper's GRACE_PERIOD computation;
  - a function next_ptr(ptr, limit) implementing the non-power-of-two wrap.
- One sub-module, rs_hs_pipeline_tail_mem, holds the storage array: one synchronous write port, one asynchronous read port, and the ram_style attribute selected by MEM_STYLE.
- Pointer, count and flag logic stays in the top module.

Test Plan:
- Fill from reset: write every cycle and keep writing for 5 cycles after if_full_n drops. if_full_n must fall in the cycle after the 28th accepted write. All 33 words are accepted, occupancy = 33, overflow = 0.
- Overflow: continue with a 34th write (0xDEAD_BEEF) at count 33 and no read. overflow = 1 and stays 1, occupancy stays 33. Draining returns words 1..33 in order and never 0xDEAD_BEEF.
- Wrap: stream 100 words (0..99) with continuous writes and reads, keeping occupancy between 1 and 3. Output must be exactly 0..99 in order, pointers wrap at 32 -> 0, if_full_n stays 1.
- Simultaneous at boundaries:
  - at count 33, read and write in the same cycle: count stays 33, new word lands at the tail;
  - at count 0, read and write in the same cycle: count becomes 1, if_empty_n rises next cycle, no word is lost.
- Empty read: if_read pulsed while empty for 10 cycles. occupancy stays 0, if_empty_n stays 0, and a subsequent write of 0x1234 reads back as 0x1234.
- Reset mid-operation: assert reset at occupancy 17 together with if_write = 1. On the next cycle occupancy = 0, if_empty_n = 0, if_full_n = 1, overflow = 0, and the first post-reset word is read first.
